tmds_channel_decoder: RTL and testbench
=======================================

# tmds_channel_decoder

Receive-side counterpart of the per-channel TMDS encoder. Consumes one word-aligned 10-bit TMDS symbol per pixel clock for one channel, tracks the HDMI period (control, video guard, video, island guard, island) with a state machine, and emits decoded video, TERC4 and control data with the same mode encoding the transmitter uses. It requests a bit slip from the upstream deserializer when it cannot find symbol alignment. Three instances (CN 0..2) sit between the deserializers and the receive-side packet and pixel logic.

## Interface
- CN, 0: channel number (0..2); selects the guard-band codes and the island-detection method.
- ALIGN_LIMIT, 16: consecutive unrecognised symbols in CONTROL before `bitslip` pulses.
- MAX_PACKETS, 18: maximum packets per data island.
- clk_pixel  in  1  pixel clock; the only clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- tmds_in  in  10  aligned symbol, sampled every clk_pixel edge.
- island_preamble  in  1  CN 1/2 only: high when the cross-channel preamble detector has seen an island preamble. Ignored when CN=0.
- mode  out  3  0=control, 1=video, 2=video guard, 3=island, 4=island guard.
- video_data  out  8  decoded pixel byte; valid when mode=1.
- data_island_data  out  4  decoded TERC4 nibble; valid when mode=3.
- control_data  out  2  last control bits. In island guard on CN0, carries bits[1:0] of the guard code (HSYNC/VSYNC).
- symbol_error  out  1  one-cycle pulse when a symbol is illegal for the current state.
- bitslip  out  1  one-cycle pulse requesting a one-bit shift upstream.

## Operation
- Decoding rules:
  - Control: 1101010100=00, 0010101011=01, 0101010100=10, 1010101011=11.
  - Video: q = tmds[7:0] ^ {8{tmds[9]}}. d0 = q0. For i>0, di = q_i ^ q_(i-1) if tmds[8]=1, else ~(q_i ^ q_(i-1)).
  - TERC4: the 16-entry table; any other code is invalid.
- Video guard code: CN0/2 = 1011001100; CN1 = 0100110011.
- Island guard code:
  - CN0: TERC4 codes 1100..1111 (1010001110, 1001110001, 0101100011, 1011000011).
  - CN1/2: 0100110011 while island_preamble=1.
- FSM states:
  - CONTROL:
    - control token -> CONTROL, update control_data.
    - video guard (CN1/2: island_preamble=0) -> VGB.
    - island guard -> IGB_LEAD.
    - otherwise: symbol_error, stay, hold outputs.
  - VGB (gb_cnt 1..2):
    - second guard symbol -> VIDEO.
    - non-guard as second symbol -> symbol_error, CONTROL.
  - VIDEO:
    - control token -> CONTROL (first control symbol output with mode=0).
    - every other symbol decoded as video.
  - IGB_LEAD:
    - second island guard -> ISLAND, sym_cnt=0, pkt_cnt=0.
    - otherwise: symbol_error, CONTROL.
  - ISLAND: sym_cnt (5 bits) increments and wraps at 31->0. On wrap, pkt_cnt increments. At a boundary (sym_cnt=0, pkt_cnt>=1):
    - CN0: a valid TERC4 code with bit3=1 is trailing guard -> IGB_TRAIL.
    - CN1/2: 0100110011 is trailing guard -> IGB_TRAIL.
    - pkt_cnt=MAX_PACKETS with no trailing guard -> symbol_error, CONTROL.
    - Invalid TERC4 code: symbol_error, data_island_data holds, stay.
  - IGB_TRAIL:
    - second trailing guard -> CONTROL.
    - otherwise: symbol_error, CONTROL.
- Alignment: align_cnt increments on each symbol_error in CONTROL and clears on any control token.
  - At ALIGN_LIMIT: bitslip pulses for one cycle and align_cnt clears.
  - No bitslip outside CONTROL.
- Reset:
  - state CONTROL; all counters 0.
  - mode=0, video_data=0, data_island_data=0, control_data=0, symbol_error=0, bitslip=0.
  - Mid-operation reset abandons any period immediately.

## Timing
- Latency 1 cycle: the symbol sampled at edge N drives registered outputs after edge N.
- mode, data and symbol_error all describe the same symbol.
- Guard symbols output mode 2/4; data outputs hold their previous value during guard symbols.
- bitslip asserts in the same cycle as the ALIGN_LIMIT-th symbol_error.
- No two bitslip pulses closer than ALIGN_LIMIT cycles.

## Structure
- Shared package `tmds_pkg`: mode enum, FSM state enum, control token constants, guard-band constants per CN, 16-entry TERC4 table. The transmitter encoder will also use this package.
- Sub-module `terc4_decoder`: combinational 10-bit -> {valid, 4-bit nibble}. The ISLAND path and the CN0 guard detection both use it.

## Test plan
- Reset, then 1101010100 -> mode=0, control_data=00. Then 0010101011 -> control_data=01 one cycle later.
- CN0: 1011001100 ×2, then 0100000000, then 1011111111, then 1101010100 -> mode 2,2,1,1,0; video_data 8'h00 then 8'hFE.
- CN0 island: guard 1010001110 ×2, 32 TERC4 symbols (first 1010011100, data 0000), then 1010001110 ×2 at the boundary -> mode 4,4,3×32,4,4, then 0; control_data=00 during guard.
- CN1 island: island_preamble=1, 0100110011 ×2, 64 symbols, 0100110011 ×2 -> trailing guard detected at sym 64; pkt_cnt=2.
- Invalid TERC4 0000000000 mid-island -> symbol_error one cycle, mode stays 3, data holds.
- Misaligned stream with 16 non-token symbols in CONTROL -> bitslip pulses exactly once, on the 16th symbol_error.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: output modes, receiver FSM states, control tokens,
// guard-band codes and the TERC4 code table used by both encoder and decoder.
package tmds_pkg;

    typedef enum logic [2:0] {
        MODE_CONTROL      = 3'd0,
        MODE_VIDEO        = 3'd1,
        MODE_VIDEO_GUARD  = 3'd2,
        MODE_ISLAND       = 3'd3,
        MODE_ISLAND_GUARD = 3'd4
    } tmds_mode_e;

    typedef enum logic [2:0] {
        ST_CONTROL   = 3'd0,
        ST_VGB       = 3'd1,
        ST_VIDEO     = 3'd2,
        ST_IGB_LEAD  = 3'd3,
        ST_ISLAND    = 3'd4,
        ST_IGB_TRAIL = 3'd5
    } rx_state_e;

    localparam logic [9:0] CTRL_TOKEN_00     = 10'b1101010100;
    localparam logic [9:0] CTRL_TOKEN_01     = 10'b0010101011;
    localparam logic [9:0] CTRL_TOKEN_10     = 10'b0101010100;
    localparam logic [9:0] CTRL_TOKEN_11     = 10'b1010101011;
    localparam logic [9:0] VIDEO_GUARD_CN02  = 10'b1011001100;
    localparam logic [9:0] VIDEO_GUARD_CN1   = 10'b0100110011;
    localparam logic [9:0] ISLAND_GUARD_CN12 = 10'b0100110011;

    function automatic logic [9:0] terc4_code(input logic [3:0] nibble);
        logic [9:0] code;
        code = '0;
        case (nibble)
            4'h0: code = 10'b1010011100;
            4'h1: code = 10'b1001100011;
            4'h2: code = 10'b1011100100;
            4'h3: code = 10'b1011100010;
            4'h4: code = 10'b0101110001;
            4'h5: code = 10'b0100011110;
            4'h6: code = 10'b0110001110;
            4'h7: code = 10'b0100111100;
            4'h8: code = 10'b1011001100;
            4'h9: code = 10'b0100111001;
            4'hA: code = 10'b0110011100;
            4'hB: code = 10'b1011000110;
            4'hC: code = 10'b1010001110;
            4'hD: code = 10'b1001110001;
            4'hE: code = 10'b0101100011;
            4'hF: code = 10'b1011000011;
            default: code = '0;
        endcase
        return code;
    endfunction

    function automatic logic [9:0] video_guard_code(input int cn);
        return (cn == 1) ? VIDEO_GUARD_CN1 : VIDEO_GUARD_CN02;
    endfunction

    // Returns {is_token, control_bits}.
    function automatic logic [2:0] ctrl_decode(input logic [9:0] sym);
        logic [2:0] r;
        r = 3'b000;
        case (sym)
            CTRL_TOKEN_00: r = 3'b100;
            CTRL_TOKEN_01: r = 3'b101;
            CTRL_TOKEN_10: r = 3'b110;
            CTRL_TOKEN_11: r = 3'b111;
            default:       r = 3'b000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/terc4_decoder.sv
// Combinational TERC4 lookup: 10-bit symbol to {valid, nibble}.
module terc4_decoder
    import tmds_pkg::*;
(
    input  logic [9:0] symbol,
    output logic       valid,
    output logic [3:0] nibble
);

    always_comb begin
        valid  = 1'b0;
        nibble = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (symbol == terc4_code(4'(i))) begin
                valid  = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// Per-channel TMDS receiver: tracks the HDMI period and decodes one aligned symbol
// per pixel clock; no handshake, every edge consumes a symbol and updates outputs.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int CN          = 0,
    parameter int ALIGN_LIMIT = 16,
    parameter int MAX_PACKETS = 18
) (
    input  logic       clk_pixel,
    input  logic       reset_n,
    input  logic [9:0] tmds_in,
    input  logic       island_preamble,
    output logic [2:0] mode,
    output logic [7:0] video_data,
    output logic [3:0] data_island_data,
    output logic [1:0] control_data,
    output logic       symbol_error,
    output logic       bitslip,
    output rx_state_e  state_dbg
);

    localparam int ALIGN_W = $clog2(ALIGN_LIMIT + 1);
    localparam int PKT_W   = $clog2(MAX_PACKETS + 1);

    rx_state_e          state_q, state_d;
    tmds_mode_e         mode_q, mode_d;
    logic [7:0]         video_data_q, video_data_d;
    logic [3:0]         island_data_q, island_data_d;
    logic [1:0]         control_data_q, control_data_d;
    logic               symbol_error_q, symbol_error_d;
    logic               bitslip_q, bitslip_d;
    logic [ALIGN_W-1:0] align_cnt_q, align_cnt_d;
    logic [4:0]         sym_cnt_q, sym_cnt_d;
    logic [PKT_W-1:0]   pkt_cnt_q, pkt_cnt_d;

    logic       t4_valid;
    logic [3:0] t4_nibble;
    logic [2:0] ctrl;
    logic [7:0] vq, vid_dec;
    logic       is_vguard, is_iguard, is_trail, at_boundary;

    terc4_decoder u_terc4 (
        .symbol (tmds_in),
        .valid  (t4_valid),
        .nibble (t4_nibble)
    );

    always_comb begin
        vq         = tmds_in[7:0] ^ {8{tmds_in[9]}};
        vid_dec[0] = vq[0];
        for (int i = 1; i < 8; i++) begin
            vid_dec[i] = tmds_in[8] ? (vq[i] ^ vq[i-1]) : ~(vq[i] ^ vq[i-1]);
        end
    end

    // CN1 shares one code for both guards, so the preamble detector disambiguates.
    always_comb begin
        ctrl        = ctrl_decode(tmds_in);
        is_vguard   = (tmds_in == video_guard_code(CN)) && ((CN == 0) || !island_preamble);
        is_iguard   = (CN == 0) ? (t4_valid && (t4_nibble[3:2] == 2'b11))
                                : ((tmds_in == ISLAND_GUARD_CN12) && island_preamble);
        is_trail    = (CN == 0) ? (t4_valid && t4_nibble[3])
                                : (tmds_in == ISLAND_GUARD_CN12);
        at_boundary = (sym_cnt_q == 5'd0) && (pkt_cnt_q != '0);
    end

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        video_data_d   = video_data_q;
        island_data_d  = island_data_q;
        control_data_d = control_data_q;
        symbol_error_d = 1'b0;
        bitslip_d      = 1'b0;
        align_cnt_d    = align_cnt_q;
        sym_cnt_d      = sym_cnt_q;
        pkt_cnt_d      = pkt_cnt_q;
        case (state_q)
            ST_CONTROL: begin
                mode_d = MODE_CONTROL;
                if (ctrl[2]) begin
                    control_data_d = ctrl[1:0];
                    align_cnt_d    = '0;
                end else if (is_vguard) begin
                    state_d = ST_VGB;
                    mode_d  = MODE_VIDEO_GUARD;
                end else if (is_iguard) begin
                    state_d = ST_IGB_LEAD;
                    mode_d  = MODE_ISLAND_GUARD;
                    if (CN == 0) control_data_d = t4_nibble[1:0];
                end else begin
                    symbol_error_d = 1'b1;
                    if (align_cnt_q == ALIGN_W'(ALIGN_LIMIT - 1)) begin
                        bitslip_d   = 1'b1;
                        align_cnt_d = '0;
                    end else begin
                        align_cnt_d = align_cnt_q + ALIGN_W'(1);
                    end
                end
            end
            ST_VGB: begin
                if (is_vguard) begin
                    state_d = ST_VIDEO;
                    mode_d  = MODE_VIDEO_GUARD;
                end else begin
                    state_d        = ST_CONTROL;
                    mode_d         = MODE_CONTROL;
                    symbol_error_d = 1'b1;
                end
            end
            ST_VIDEO: begin
                if (ctrl[2]) begin
                    state_d        = ST_CONTROL;
                    mode_d         = MODE_CONTROL;
                    control_data_d = ctrl[1:0];
                    align_cnt_d    = '0;
                end else begin
                    mode_d       = MODE_VIDEO;
                    video_data_d = vid_dec;
                end
            end
            ST_IGB_LEAD: begin
                if (is_iguard) begin
                    state_d   = ST_ISLAND;
                    mode_d    = MODE_ISLAND_GUARD;
                    sym_cnt_d = '0;
                    pkt_cnt_d = '0;
                    if (CN == 0) control_data_d = t4_nibble[1:0];
                end else begin
                    state_d        = ST_CONTROL;
                    mode_d         = MODE_CONTROL;
                    symbol_error_d = 1'b1;
                end
            end
            ST_ISLAND: begin
                if (at_boundary && is_trail) begin
                    state_d = ST_IGB_TRAIL;
                    mode_d  = MODE_ISLAND_GUARD;
                    if (CN == 0) control_data_d = t4_nibble[1:0];
                end else if (at_boundary && (pkt_cnt_q == PKT_W'(MAX_PACKETS))) begin
                    state_d        = ST_CONTROL;
                    mode_d         = MODE_CONTROL;
                    symbol_error_d = 1'b1;
                end else begin
                    mode_d    = MODE_ISLAND;
                    sym_cnt_d = sym_cnt_q + 5'd1;
                    if (sym_cnt_q == 5'd31) pkt_cnt_d = pkt_cnt_q + PKT_W'(1);
                    if (t4_valid) island_data_d = t4_nibble;
                    else          symbol_error_d = 1'b1;
                end
            end
            ST_IGB_TRAIL: begin
                state_d = ST_CONTROL;
                if (is_trail) begin
                    mode_d = MODE_ISLAND_GUARD;
                    if (CN == 0) control_data_d = t4_nibble[1:0];
                end else begin
                    mode_d         = MODE_CONTROL;
                    symbol_error_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_CONTROL;
                mode_d  = MODE_CONTROL;
            end
        endcase
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_CONTROL;
            mode_q         <= MODE_CONTROL;
            video_data_q   <= '0;
            island_data_q  <= '0;
            control_data_q <= '0;
            symbol_error_q <= 1'b0;
            bitslip_q      <= 1'b0;
            align_cnt_q    <= '0;
            sym_cnt_q      <= '0;
            pkt_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            video_data_q   <= video_data_d;
            island_data_q  <= island_data_d;
            control_data_q <= control_data_d;
            symbol_error_q <= symbol_error_d;
            bitslip_q      <= bitslip_d;
            align_cnt_q    <= align_cnt_d;
            sym_cnt_q      <= sym_cnt_d;
            pkt_cnt_q      <= pkt_cnt_d;
        end
    end

    assign mode             = mode_q;
    assign video_data       = video_data_q;
    assign data_island_data = island_data_q;
    assign control_data     = control_data_q;
    assign symbol_error     = symbol_error_q;
    assign bitslip          = bitslip_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: a CN0 and a CN1 instance, each checked
// by a monitor that pops a packed expected-response queue every cycle it was fed.
module tb_tmds_channel_decoder;
    import tmds_pkg::*;

    localparam int EW = 19;  // {mode[3], video[8], island[4], ctrl[2], err, slip}

    logic       clk = 1'b0;
    logic       rst0_n, rst1_n;
    logic [9:0] tin0, tin1;
    logic       pre0, pre1;
    logic [2:0] mode0, mode1;
    logic [7:0] vid0, vid1;
    logic [3:0] isl0, isl1;
    logic [1:0] ctl0, ctl1;
    logic       err0, err1, slip0, slip1;
    rx_state_e  st0, st1;

    logic          act0, act1;
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [9:0]    t4 [16];
    int            n_checks = 0;
    int            n_pass = 0;
    string         tag = "reset";

    wire [EW-1:0] out0 = {mode0, vid0, isl0, ctl0, err0, slip0};
    wire [EW-1:0] out1 = {mode1, vid1, isl1, ctl1, err1, slip1};

    always #5 clk = ~clk;

    tmds_channel_decoder #(.CN(0), .ALIGN_LIMIT(16), .MAX_PACKETS(18)) dut0 (
        .clk_pixel(clk), .reset_n(rst0_n), .tmds_in(tin0), .island_preamble(pre0),
        .mode(mode0), .video_data(vid0), .data_island_data(isl0), .control_data(ctl0),
        .symbol_error(err0), .bitslip(slip0), .state_dbg(st0)
    );

    tmds_channel_decoder #(.CN(1), .ALIGN_LIMIT(16), .MAX_PACKETS(18)) dut1 (
        .clk_pixel(clk), .reset_n(rst1_n), .tmds_in(tin1), .island_preamble(pre1),
        .mode(mode1), .video_data(vid1), .data_island_data(isl1), .control_data(ctl1),
        .symbol_error(err1), .bitslip(slip1), .state_dbg(st1)
    );

    function automatic logic [EW-1:0] ex(input logic [2:0] m, input logic [7:0] v,
                                         input logic [3:0] i, input logic [1:0] c,
                                         input logic e, input logic s);
        return {m, v, i, c, e, s};
    endfunction

    task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] req);
        n_checks++;
        if (got === req) n_pass++;
        else $display("FAIL %s: got mode=%0d vid=%h isl=%h ctrl=%b err=%b slip=%b, required mode=%0d vid=%h isl=%h ctrl=%b err=%b slip=%b",
                      name, got[18:16], got[15:8], got[7:4], got[3:2], got[1], got[0],
                      req[18:16], req[15:8], req[7:4], req[3:2], req[1], req[0]);
    endtask

    task automatic send(input int ch, input logic [9:0] s, input logic pre, input logic [EW-1:0] e);
        @(posedge clk);
        #1;
        if (ch == 0) begin
            tin0 = s; pre0 = pre; act0 = 1'b1; act1 = 1'b0;
            exp_q0.push_back(e);
        end else begin
            tin1 = s; pre1 = pre; act1 = 1'b1; act0 = 1'b0;
            exp_q1.push_back(e);
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        @(posedge clk);
        #1;
        act0 = 1'b0;
        act1 = 1'b0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            n_checks++;
            $display("FAIL drain %s: %0d responses outstanding, required 0", tag,
                     exp_q0.size() + exp_q1.size());
            exp_q0.delete();
            exp_q1.delete();
        end
    endtask

    // Monitors: a symbol sampled at a posedge while its channel was active is checked at the next negedge.
    initial begin
        logic t;
        int   idx;
        idx = 0;
        forever begin
            @(posedge clk);
            t = act0;
            @(negedge clk);
            if (t) begin
                if (exp_q0.size() == 0) begin
                    n_checks++;
                    $display("FAIL ch0 %s: output with empty expected queue, required queued entry", tag);
                end else begin
                    check($sformatf("ch0 %s #%0d", tag, idx), out0, exp_q0.pop_front());
                end
                idx++;
            end
        end
    end

    initial begin
        logic t;
        int   idx;
        idx = 0;
        forever begin
            @(posedge clk);
            t = act1;
            @(negedge clk);
            if (t) begin
                if (exp_q1.size() == 0) begin
                    n_checks++;
                    $display("FAIL ch1 %s: output with empty expected queue, required queued entry", tag);
                end else begin
                    check($sformatf("ch1 %s #%0d", tag, idx), out1, exp_q1.pop_front());
                end
                idx++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        t4 = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
               10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
               10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
               10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
        rst0_n = 1'b0; rst1_n = 1'b0;
        tin0 = 10'b1101010100; tin1 = 10'b1101010100;
        pre0 = 1'b0; pre1 = 1'b0; act0 = 1'b0; act1 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ch0", out0, '0);
        check("reset ch1", out1, '0);
        @(posedge clk);
        #1 rst0_n = 1'b1;

        tag = "control";
        send(0, 10'b1101010100, 0, ex(0, 8'h00, 4'h0, 2'b00, 0, 0));
        send(0, 10'b0010101011, 0, ex(0, 8'h00, 4'h0, 2'b01, 0, 0));

        tag = "video";
        send(0, 10'b1011001100, 0, ex(2, 8'h00, 4'h0, 2'b01, 0, 0));
        send(0, 10'b1011001100, 0, ex(2, 8'h00, 4'h0, 2'b01, 0, 0));
        send(0, 10'b0100000000, 0, ex(1, 8'h00, 4'h0, 2'b01, 0, 0));
        send(0, 10'b1011111111, 0, ex(1, 8'hFE, 4'h0, 2'b01, 0, 0));
        send(0, 10'b1101010100, 0, ex(0, 8'hFE, 4'h0, 2'b00, 0, 0));

        tag = "island0";
        repeat (2) send(0, 10'b1010001110, 0, ex(4, 8'hFE, 4'h0, 2'b00, 0, 0));
        for (int i = 0; i < 32; i++) send(0, t4[i[3:0]], 0, ex(3, 8'hFE, i[3:0], 2'b00, 0, 0));
        repeat (2) send(0, 10'b1010001110, 0, ex(4, 8'hFE, 4'hF, 2'b00, 0, 0));
        send(0, 10'b1101010100, 0, ex(0, 8'hFE, 4'hF, 2'b00, 0, 0));

        tag = "bad_terc4";
        repeat (2) send(0, 10'b1001110001, 0, ex(4, 8'hFE, 4'hF, 2'b01, 0, 0));
        send(0, 10'b1010011100, 0, ex(3, 8'hFE, 4'h0, 2'b01, 0, 0));
        send(0, 10'b0000000000, 0, ex(3, 8'hFE, 4'h0, 2'b01, 1, 0));
        send(0, 10'b1001100011, 0, ex(3, 8'hFE, 4'h1, 2'b01, 0, 0));
        repeat (29) send(0, 10'b1011100100, 0, ex(3, 8'hFE, 4'h2, 2'b01, 0, 0));
        repeat (2) send(0, 10'b1011000011, 0, ex(4, 8'hFE, 4'h2, 2'b11, 0, 0));
        send(0, 10'b0101010100, 0, ex(0, 8'hFE, 4'h2, 2'b10, 0, 0));

        tag = "max_packets";
        repeat (2) send(0, 10'b1010001110, 0, ex(4, 8'hFE, 4'h2, 2'b00, 0, 0));
        repeat (576) send(0, 10'b1010011100, 0, ex(3, 8'hFE, 4'h0, 2'b00, 0, 0));
        send(0, 10'b1010011100, 0, ex(0, 8'hFE, 4'h0, 2'b00, 1, 0));
        send(0, 10'b1101010100, 0, ex(0, 8'hFE, 4'h0, 2'b00, 0, 0));

        tag = "bitslip";
        for (int i = 0; i < 20; i++)
            send(0, 10'b0000011111, 0, ex(0, 8'hFE, 4'h0, 2'b00, 1, (i == 15)));
        send(0, 10'b1101010100, 0, ex(0, 8'hFE, 4'h0, 2'b00, 0, 0));

        tag = "vgb_fail";
        send(0, 10'b1011001100, 0, ex(2, 8'hFE, 4'h0, 2'b00, 0, 0));
        send(0, 10'b1010101011, 0, ex(0, 8'hFE, 4'h0, 2'b00, 1, 0));
        send(0, 10'b0010101011, 0, ex(0, 8'hFE, 4'h0, 2'b01, 0, 0));
        drain();

        rst0_n = 1'b0;
        tin1 = 10'b1101010100;
        @(posedge clk);
        #1 rst1_n = 1'b1;

        tag = "cn1_island";
        send(1, 10'b1101010100, 0, ex(0, 8'h00, 4'h0, 2'b00, 0, 0));
        repeat (2) send(1, 10'b0100110011, 1, ex(4, 8'h00, 4'h0, 2'b00, 0, 0));
        for (int i = 0; i < 64; i++) send(1, t4[i[3:0]], 0, ex(3, 8'h00, i[3:0], 2'b00, 0, 0));
        repeat (2) send(1, 10'b0100110011, 0, ex(4, 8'h00, 4'hF, 2'b00, 0, 0));
        send(1, 10'b1101010100, 0, ex(0, 8'h00, 4'hF, 2'b00, 0, 0));

        tag = "cn1_video";
        repeat (2) send(1, 10'b0100110011, 0, ex(2, 8'h00, 4'hF, 2'b00, 0, 0));
        send(1, 10'b1000000001, 0, ex(1, 8'hFC, 4'hF, 2'b00, 0, 0));
        send(1, 10'b1010101011, 0, ex(0, 8'hFC, 4'hF, 2'b11, 0, 0));
        repeat (2) send(1, 10'b0100110011, 0, ex(2, 8'hFC, 4'hF, 2'b11, 0, 0));
        send(1, 10'b1011111111, 0, ex(1, 8'hFE, 4'hF, 2'b11, 0, 0));
        drain();

        tag = "mid_reset";
        @(negedge clk);
        rst1_n = 1'b0;
        #1;
        check("async reset ch1", out1, '0);
        n_checks++;
        if (st1 == ST_CONTROL) n_pass++;
        else $display("FAIL async reset state ch1: got %0d, required %0d", st1, ST_CONTROL);
        tin1 = 10'b1101010100;
        @(posedge clk);
        #1 rst1_n = 1'b1;
        send(1, 10'b0100000000, 0, ex(0, 8'h00, 4'h0, 2'b00, 1, 0));
        send(1, 10'b0010101011, 0, ex(0, 8'h00, 4'h0, 2'b01, 0, 0));
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
